bus_sequencer: RTL and testbench

Micro-sequencer for the downsampling processor datapath. Fetches instruction bytes, decodes them, and sequences each instruction over the shared B bus. It drives the B-bus source select, the C-bus register write enables, the ALU operation and the instruction/data memory request handshakes. It sits between instruction/data memory and the register file / B-bus multiplexer / ALU, and is the only driver of their control inputs.

---
 rtl/proc_pkg.sv | 59 +++++
 rtl/instr_decode.sv | 85 ++++++++
 rtl/bus_sequencer.sv | 130 +++++++++++++
 tb/tb_bus_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared encodings for the downsampling processor control path: opcodes, B-bus sources,
// C-bus write-enable indices, ALU operations and sequencer states.
package proc_pkg;

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpLdac  = 4'h1;
  localparam logic [3:0] OpStac  = 4'h2;
  localparam logic [3:0] OpAdd   = 4'h3;
  localparam logic [3:0] OpSub   = 4'h4;
  localparam logic [3:0] OpInc   = 4'h5;
  localparam logic [3:0] OpLoad  = 4'h6;
  localparam logic [3:0] OpStore = 4'h7;
  localparam logic [3:0] OpJmpz  = 4'h8;
  localparam logic [3:0] OpJmp   = 4'h9;
  localparam logic [3:0] OpEnd   = 4'hF;

  localparam logic [3:0] BNone = 4'd0;
  localparam logic [3:0] BMdr  = 4'd1;
  localparam logic [3:0] BPc   = 4'd2;
  localparam logic [3:0] BMbru = 4'd3;
  localparam logic [3:0] BL    = 4'd4;
  localparam logic [3:0] BC1   = 4'd5;
  localparam logic [3:0] BC2   = 4'd6;
  localparam logic [3:0] BC3   = 4'd7;
  localparam logic [3:0] BT    = 4'd8;
  localparam logic [3:0] BE    = 4'd9;

  // Bits 1-9 of c_we share numbering with the B-bus codes.
  localparam int unsigned NumWe = 10;
  localparam logic [3:0] CweAc   = 4'd0;
  localparam logic [3:0] CweMdr  = 4'd1;
  localparam logic [3:0] CwePc   = 4'd2;
  localparam logic [3:0] CweMbru = 4'd3;

  localparam logic [2:0] AluPass = 3'd0;
  localparam logic [2:0] AluAdd  = 3'd1;
  localparam logic [2:0] AluSub  = 3'd2;
  localparam logic [2:0] AluInc  = 3'd3;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StOpnd   = 3'd4;
  localparam logic [2:0] StMem    = 3'd5;
  localparam logic [2:0] StHalt   = 3'd6;

  typedef enum logic [3:0] {
    ClsNop, ClsLdac, ClsStac, ClsAdd, ClsSub, ClsInc,
    ClsLoad, ClsStore, ClsJmpz, ClsJmp, ClsEnd, ClsIllegal
  } instr_class_e;

  function automatic logic [NumWe-1:0] we_onehot(input logic [3:0] idx);
    for (int i = 0; i < NumWe; i++) begin
      we_onehot[i] = (idx == 4'(i));
    end
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: classifies IR and supplies the EXEC-cycle control fields.
module instr_decode
  import proc_pkg::*;
(
  input  logic [7:0]   ir_i,
  output instr_class_e cls_o,
  output logic         illegal_o,
  output logic [3:0]   b_sel_o,
  output logic [2:0]   alu_op_o,
  output logic         we_en_o,
  output logic [3:0]   we_idx_o
);

  logic [3:0] op;
  logic [3:0] r;
  logic       r_ok;
  logic       r_zero;

  assign op     = ir_i[7:4];
  assign r      = ir_i[3:0];
  assign r_ok   = (r >= 4'd1) && (r <= 4'd9);
  assign r_zero = (r == 4'd0);

  always_comb begin
    cls_o    = ClsIllegal;
    b_sel_o  = BNone;
    alu_op_o = AluPass;
    we_en_o  = 1'b0;
    we_idx_o = CweAc;
    case (op)
      OpNop:   if (r_zero) cls_o = ClsNop;
      OpLdac:  if (r_ok) begin
        cls_o    = ClsLdac;
        b_sel_o  = r;
        we_en_o  = 1'b1;
        we_idx_o = CweAc;
      end
      OpStac:  if (r_ok) begin
        cls_o    = ClsStac;
        we_en_o  = 1'b1;
        we_idx_o = r;
      end
      OpAdd:   if (r_ok) begin
        cls_o    = ClsAdd;
        b_sel_o  = r;
        alu_op_o = AluAdd;
        we_en_o  = 1'b1;
        we_idx_o = CweAc;
      end
      OpSub:   if (r_ok) begin
        cls_o    = ClsSub;
        b_sel_o  = r;
        alu_op_o = AluSub;
        we_en_o  = 1'b1;
        we_idx_o = CweAc;
      end
      OpInc:   if (r_ok) begin
        cls_o    = ClsInc;
        b_sel_o  = r;
        alu_op_o = AluInc;
        we_en_o  = 1'b1;
        we_idx_o = r;
      end
      OpLoad:  if (r_zero) cls_o = ClsLoad;
      OpStore: if (r_zero) cls_o = ClsStore;
      // Jumps move MBRU into PC; the FSM gates the write on z_flag for JMPZ.
      OpJmpz:  if (r_zero) begin
        cls_o    = ClsJmpz;
        b_sel_o  = BMbru;
        we_en_o  = 1'b1;
        we_idx_o = CwePc;
      end
      OpJmp:   if (r_zero) begin
        cls_o    = ClsJmp;
        b_sel_o  = BMbru;
        we_en_o  = 1'b1;
        we_idx_o = CwePc;
      end
      OpEnd:   if (r_zero) cls_o = ClsEnd;
      default: ;
    endcase
    illegal_o = (cls_o == ClsIllegal);
  end

endmodule

// File: rtl/bus_sequencer.sv
// Micro-sequencer: fetches, decodes and sequences instructions over the shared B bus,
// driving the register write enables, ALU op and memory request handshakes.
module bus_sequencer
  import proc_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             im_rd_o,
  input  logic             im_ack_i,
  input  logic [7:0]       im_data_i,
  output logic             dm_rd_o,
  output logic             dm_wr_o,
  input  logic             dm_ack_i,
  input  logic             z_flag_i,
  output logic [3:0]       b_bus_ctrl_o,
  output logic [NumWe-1:0] c_we_o,
  output logic [2:0]       alu_op_o,
  output logic             pc_inc_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  logic [2:0]   state_q, state_d;
  logic [7:0]   ir_q, ir_d;
  logic         im_ack_ok, dm_ack_ok;

  instr_class_e dec_cls;
  logic         dec_illegal;
  logic [3:0]   dec_b_sel;
  logic [2:0]   dec_alu_op;
  logic         dec_we_en;
  logic [3:0]   dec_we_idx;

  instr_decode u_instr_decode (
    .ir_i      (ir_q),
    .cls_o     (dec_cls),
    .illegal_o (dec_illegal),
    .b_sel_o   (dec_b_sel),
    .alu_op_o  (dec_alu_op),
    .we_en_o   (dec_we_en),
    .we_idx_o  (dec_we_idx)
  );

  // Ack-cycle strobes are suppressed while reset is asserted so nothing is written back.
  assign im_ack_ok = im_ack_i & rst_ni;
  assign dm_ack_ok = dm_ack_i & rst_ni;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    im_rd_o      = 1'b0;
    dm_rd_o      = 1'b0;
    dm_wr_o      = 1'b0;
    b_bus_ctrl_o = BNone;
    c_we_o       = '0;
    alu_op_o     = AluPass;
    pc_inc_o     = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        im_rd_o = 1'b1;
        if (im_ack_ok) begin
          ir_d     = im_data_i;
          pc_inc_o = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        if (dec_illegal || dec_cls == ClsEnd) begin
          state_d = StHalt;
        end else if (dec_cls == ClsLoad || dec_cls == ClsStore) begin
          state_d = StMem;
        end else if (dec_cls == ClsJmp || dec_cls == ClsJmpz) begin
          state_d = StOpnd;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        b_bus_ctrl_o = dec_b_sel;
        alu_op_o     = dec_alu_op;
        if (dec_we_en && (dec_cls != ClsJmpz || z_flag_i)) begin
          c_we_o = we_onehot(dec_we_idx);
        end
        state_d = StFetch;
      end
      StOpnd: begin
        im_rd_o = 1'b1;
        if (im_ack_ok) begin
          c_we_o   = we_onehot(CweMbru);
          pc_inc_o = 1'b1;
          state_d  = StExec;
        end
      end
      StMem: begin
        dm_rd_o = (dec_cls == ClsLoad);
        dm_wr_o = (dec_cls == ClsStore);
        if (dm_ack_ok) begin
          if (dec_cls == ClsLoad) c_we_o = we_onehot(CweMdr);
          state_d = StFetch;
        end
      end
      StHalt: begin
        // IR still holds the byte that halted us, so done/err need no extra state.
        done_o = (dec_cls == ClsEnd);
        err_o  = (dec_cls != ClsEnd);
        if (start_i) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
    busy_o = (state_q != StIdle) && (state_q != StHalt);
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: directed programs from a small instruction memory model,
// expected C-bus writes queued at issue and checked by an independent monitor.
module tb_bus_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       im_ack, dm_ack, z_flag;
  logic [7:0] im_data;
  logic       im_rd, dm_rd, dm_wr, pc_inc, busy, done, err;
  logic [3:0] b_bus;
  logic [9:0] c_we;
  logic [2:0] alu_op;

  bus_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .im_rd_o      (im_rd),
    .im_ack_i     (im_ack),
    .im_data_i    (im_data),
    .dm_rd_o      (dm_rd),
    .dm_wr_o      (dm_wr),
    .dm_ack_i     (dm_ack),
    .z_flag_i     (z_flag),
    .b_bus_ctrl_o (b_bus),
    .c_we_o       (c_we),
    .alu_op_o     (alu_op),
    .pc_inc_o     (pc_inc),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] b;
    logic [9:0] we;
    logic [2:0] alu;
  } wr_t;

  wr_t        exp_q[$];
  int         errors = 0;
  int         checks = 0;

  logic [7:0] imem [256];
  logic [7:0] pc = 8'h00;
  logic [7:0] mbru = 8'h00;
  logic       im_hold = 1'b0;
  int         dm_delay = 0;
  int         busy_cnt, pcinc_cnt, dmrd_cnt, dmwr_cnt, we1_cnt, we1_noack, viol;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [3:0] b, input logic [9:0] we, input logic [2:0] alu);
    wr_t e;
    e.b = b; e.we = we; e.alu = alu;
    exp_q.push_back(e);
  endtask

  task automatic clr_cnt();
    busy_cnt = 0; pcinc_cnt = 0; dmrd_cnt = 0; dmwr_cnt = 0; we1_cnt = 0; we1_noack = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (n < 60) begin
      @(negedge clk);
      #3;
      if (done || err) break;
      n++;
    end
    if (n >= 60) begin
      errors++; checks++;
      $display("FAIL %s_timeout: got no halt in 60 cycles, required done or err", name);
    end
  endtask

  // Memory model: zero-wait instruction memory, data memory with dm_delay wait cycles.
  initial begin
    logic inc_pend, pcw_pend;
    int   dm_cnt;
    inc_pend = 1'b0; pcw_pend = 1'b0; dm_cnt = 0;
    im_ack = 1'b0; dm_ack = 1'b0; im_data = 8'h00; z_flag = 1'b0;
    viol = 0;
    forever begin
      @(negedge clk);
      if (inc_pend) pc = pc + 8'd1;
      if (pcw_pend) pc = mbru;
      inc_pend = 1'b0;
      pcw_pend = 1'b0;
      im_data  = imem[pc];
      im_ack   = im_rd && !im_hold;
      if (dm_rd || dm_wr) begin
        dm_ack = (dm_cnt == dm_delay);
        dm_cnt++;
      end else begin
        dm_ack = 1'b0;
        dm_cnt = 0;
      end
      #2;
      if (rst_n) begin
        inc_pend = pc_inc;
        pcw_pend = c_we[2];
        if (c_we[3]) mbru = im_data;
        busy_cnt  += int'(busy);
        pcinc_cnt += int'(pc_inc);
        dmrd_cnt  += int'(dm_rd);
        dmwr_cnt  += int'(dm_wr);
        we1_cnt   += int'(c_we[1]);
        we1_noack += int'(c_we[1] && !dm_ack);
        if ($countones(c_we) > 1 || (dm_rd && dm_wr)) viol++;
      end
    end
  end

  // Monitor: every C-bus write must match the next queued expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && c_we != '0) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL sb_unexpected: got b=%0d we=0x%03h alu=%0d, required no write",
                   b_bus, c_we, alu_op);
        end else begin
          e = exp_q.pop_front();
          check("sb_write", 32'({b_bus, c_we, alu_op}), 32'(e));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 8'hFF;
    imem[8'h00] = 8'h14; imem[8'h01] = 8'h35; imem[8'h02] = 8'h28; imem[8'h03] = 8'hF0;
    imem[8'h04] = 8'h60; imem[8'h05] = 8'hF0;
    imem[8'h06] = 8'h70; imem[8'h07] = 8'hF0;
    imem[8'h08] = 8'h80; imem[8'h09] = 8'h20; imem[8'h20] = 8'hF0;
    imem[8'h21] = 8'h80; imem[8'h22] = 8'h30; imem[8'h23] = 8'h90; imem[8'h24] = 8'h40;
    imem[8'h40] = 8'hF0;
    imem[8'h41] = 8'h1A; imem[8'h42] = 8'hA0; imem[8'h43] = 8'h00; imem[8'h44] = 8'hF0;
    clr_cnt();

    // Reset, then idle with all outputs low.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      check("reset_outputs",
            32'({im_rd, dm_rd, dm_wr, b_bus, c_we, alu_op, pc_inc, busy, done, err}), 32'd0);
      @(negedge clk);
    end

    // LDAC L; ADD C1; STAC T; END
    expect_wr(BL_C(4), 10'h001, 3'd0);
    expect_wr(4'd5, 10'h001, 3'd1);
    expect_wr(4'd0, 10'h100, 3'd0);
    clr_cnt();
    pulse_start();
    wait_halt("prog_a");
    check("prog_a_done", 32'({done, err}), 32'b10);
    check("prog_a_pc_inc", pcinc_cnt, 4);
    check("prog_a_busy_cycles", busy_cnt, 11);
    check("prog_a_pc", 32'(pc), 32'h04);
    check("prog_a_sb_empty", exp_q.size(), 0);

    // LOAD with three wait cycles
    dm_delay = 3;
    expect_wr(4'd0, 10'h002, 3'd0);
    clr_cnt();
    pulse_start();
    wait_halt("load");
    check("load_done", 32'({done, err}), 32'b10);
    check("load_dm_rd_cycles", dmrd_cnt, 4);
    check("load_dm_wr_cycles", dmwr_cnt, 0);
    check("load_mdr_we_cycles", we1_cnt, 1);
    check("load_mdr_we_without_ack", we1_noack, 0);
    check("load_sb_empty", exp_q.size(), 0);

    // STORE zero-wait: no register write
    dm_delay = 0;
    clr_cnt();
    pulse_start();
    wait_halt("store");
    check("store_done", 32'({done, err}), 32'b10);
    check("store_dm_wr_cycles", dmwr_cnt, 1);
    check("store_dm_rd_cycles", dmrd_cnt, 0);

    // JMPZ 0x20 taken
    z_flag = 1'b1;
    expect_wr(4'd0, 10'h008, 3'd0);
    expect_wr(4'd3, 10'h004, 3'd0);
    clr_cnt();
    pulse_start();
    wait_halt("jmpz_taken");
    check("jmpz_taken_done", 32'({done, err}), 32'b10);
    check("jmpz_taken_pc", 32'(pc), 32'h21);
    check("jmpz_taken_pc_inc", pcinc_cnt, 3);
    check("jmpz_taken_sb_empty", exp_q.size(), 0);

    // JMPZ not taken falls through to JMP 0x40
    z_flag = 1'b0;
    expect_wr(4'd0, 10'h008, 3'd0);
    expect_wr(4'd0, 10'h008, 3'd0);
    expect_wr(4'd3, 10'h004, 3'd0);
    clr_cnt();
    pulse_start();
    wait_halt("jmpz_not_taken");
    check("jmpz_nt_done", 32'({done, err}), 32'b10);
    check("jmpz_nt_pc", 32'(pc), 32'h41);
    check("jmpz_nt_sb_empty", exp_q.size(), 0);

    // Illegal register 0x1A, then illegal opcode 0xA0
    pulse_start();
    wait_halt("ill_reg");
    check("ill_reg_status", 32'({done, err}), 32'b01);
    check("ill_reg_pc", 32'(pc), 32'h42);
    pulse_start();
    #3;
    check("ill_reg_err_cleared", 32'({done, err, busy}), 32'b001);
    wait_halt("ill_op");
    check("ill_op_status", 32'({done, err}), 32'b01);
    clr_cnt();
    pulse_start();
    #3;
    check("ill_op_err_cleared", 32'({done, err}), 32'b00);
    wait_halt("nop_end");
    check("nop_end_status", 32'({done, err}), 32'b10);
    check("nop_end_pc_inc", pcinc_cnt, 2);
    check("nop_end_pc", 32'(pc), 32'h45);

    // Reset during a stalled fetch, with start asserted alongside reset
    im_hold = 1'b1;
    clr_cnt();
    pulse_start();
    #3;
    check("stall_fetch", 32'({im_rd, busy}), 32'b11);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    #3;
    check("reset_mid_fetch",
          32'({im_rd, dm_rd, dm_wr, b_bus, c_we, alu_op, pc_inc, busy, done, err}), 32'd0);
    @(negedge clk);
    #3;
    check("start_with_reset_ignored", 32'({busy, im_rd}), 32'b00);
    check("reset_no_pc_inc", pcinc_cnt, 0);
    im_hold = 1'b0;

    check("invariants", viol, 0);
    check("sb_final_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [3:0] BL_C(input int v);
    return 4'(v);
  endfunction

endmodule
